stop_it_ng: RTL and testbench
=============================

Name: stop_it_ng

Overview:
Next-generation Stop-It game controller, parametrised in LED count, counter width and timing, with lives, a LOST state and selectable difficulty. Self-contained: it contains its own LFSR, phase timer, down-counter, lives counter and LED register. It runs on one fast clock with a tick strobe instead of a dedicated 4 Hz clock. It drives the board LEDs and the target/count display values consumed by the seven-segment driver.

Parameters:
LEDS, 16, width of LED register and switch input (2..32)
COUNT_W, 8, width of target and count values (1..16)
START_TICKS, 8, ticks spent in STARTING (>=1)
RESULT_TICKS, 16, ticks spent in WRONG/CORRECT (>=1)
LIVES, 3, lives granted per game (1..15)
SEED, 16'h0001, LFSR reset value (nonzero)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
tick_i  in  1  one-cycle game-time strobe
go_i  in  1  start/acknowledge button (debounced, level)
stop_i  in  1  stop button (debounced, level)
load_i  in  1  load switches into LED register
level_i  in  2  difficulty: decrement every 2^(3-level_i) ticks
switches_i  in  LEDS  LED preload pattern
leds_o  out  LEDS  LED display
target_o  out  COUNT_W  target value
target_en_o  out  1  target display enable
count_o  out  COUNT_W  running count
count_en_o  out  1  count display enable
lives_o  out  4  remaining lives
state_o  out  3  encoded state: 0 WAITING_TO_START, 1 STARTING, 2 DECREMENTING, 3 WRONG, 4 CORRECT, 5 WON, 6 LOST

Behaviour:
- Reset (async assert, sync release) sets the following: state WAITING_TO_START, LED register 0, leds_o 0, target 0, count all-ones, lives LIVES, LFSR SEED, timers 0, and all enables 0.
- LFSR: 16-bit Fibonacci with taps 16,14,13,11. It advances every clk_i cycle regardless of state. target := lfsr[COUNT_W-1:0], captured on every entry to STARTING.
- Phase timer counts tick_i pulses and clears on every state change.
- WAITING_TO_START:
  - target_en_o=0, count_en_o=0.
  - load_i=1 loads switches_i into the LED register the next cycle.
  - go_i=1 goes to STARTING, reloads lives=LIVES and captures target. go_i takes priority over load_i in the same cycle: the transition happens and no load occurs.
- STARTING:
  - target_en_o=1, count_en_o=0, count := all-ones.
  - After START_TICKS ticks, go to DECREMENTING.
- DECREMENTING:
  - target_en_o=1, count_en_o=1.
  - Prescaler counts ticks. On each 2^(3-level_i)-th tick, count decrements and wraps from 0 to all-ones. level_i is sampled live.
  - stop_i=1 compares the registered count (pre-decrement if a step coincides) with target. Equal goes to CORRECT, otherwise WRONG.
- CORRECT:
  - On entry, the LED register shifts left by one with 1 inserted at bit 0.
  - count is frozen. leds_o = LED register.
  - After RESULT_TICKS ticks: if the LED register is all-ones, go to WON; else go to STARTING with a new target.
- WRONG:
  - On entry, lives decrements (saturates at 0).
  - count is frozen. leds_o = LED register XOR a blink mask that toggles all-ones/all-zeros each tick.
  - After RESULT_TICKS ticks: if lives==0, go to LOST; else go to STARTING.
- WON: leds_o blinks all LEDs each tick. go_i returns to WAITING_TO_START with the LED register kept.
- LOST: leds_o=0, target_en_o=1, count_en_o=1 (shows miss). go_i returns to WAITING_TO_START with the LED register cleared.
- Buttons are ignored in STARTING, CORRECT and WRONG. stop_i is ignored outside DECREMENTING. load_i is ignored outside WAITING_TO_START.
- Held go_i across WON/LOST→WAITING→STARTING is legal: each transition consumes one cycle.
- Illegal state encoding goes to WAITING_TO_START on the next clock.
- Reset mid-game restores all reset values immediately, including lives and LFSR.
- Outputs are registered or a decode of registered state only; there are no input-to-output combinational paths.

Test Plan:
1. Reset, load_i with switches_i=16'h7FFF, go_i, then stop_i when count==target → CORRECT, leds_o=16'hFFFF after shift; after 16 ticks, state_o=5 (WON).
2. Reset, go_i, wait 8 ticks, stop_i when count!=target → WRONG, lives_o 3→2; after 16 ticks, state_o=1 with a new target captured.
3. Three consecutive wrong stops → lives_o=0, state_o=6 (LOST), leds_o=0; go_i → state_o=0 with the LED register cleared.
4. level_i=3 versus level_i=0 in DECREMENTING → count decrements every tick versus every 8 ticks; count wraps 0→255 (COUNT_W=8).
5. stop_i on the same cycle as a decrement step, with the pre-step count equal to target → CORRECT (pre-decrement value compared).
6. Assert rst_i asynchronously mid-DECREMENTING, between clock edges → state_o=0, leds_o=0, lives_o=3 immediately; go_i and load_i asserted together in WAITING → STARTING with the LED register unchanged.

Source files
------------

// File: rtl/stop_it_ng.sv
// Stop-It game controller: LFSR target, tick-paced down-counter, lives and LED score register.
// rst_i asserts asynchronously; its release is expected to be synchronous to clk_i.
module stop_it_ng #(
    parameter int          LEDS         = 16,
    parameter int          COUNT_W      = 8,
    parameter int          START_TICKS  = 8,
    parameter int          RESULT_TICKS = 16,
    parameter int          LIVES        = 3,
    parameter logic [15:0] SEED         = 16'h0001
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               tick_i,
    input  logic               go_i,
    input  logic               stop_i,
    input  logic               load_i,
    input  logic [1:0]         level_i,
    input  logic [LEDS-1:0]    switches_i,
    output logic [LEDS-1:0]    leds_o,
    output logic [COUNT_W-1:0] target_o,
    output logic               target_en_o,
    output logic [COUNT_W-1:0] count_o,
    output logic               count_en_o,
    output logic [3:0]         lives_o,
    output logic [2:0]         state_o
);

    localparam logic [2:0] S_WAIT    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DEC     = 3'd2;
    localparam logic [2:0] S_WRONG   = 3'd3;
    localparam logic [2:0] S_CORRECT = 3'd4;
    localparam logic [2:0] S_WON     = 3'd5;
    localparam logic [2:0] S_LOST    = 3'd6;

    localparam int PH_MAX = (START_TICKS > RESULT_TICKS) ? START_TICKS : RESULT_TICKS;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic               w_chg;
    logic [15:0]        r_lfsr;
    logic               w_lfsr_fb;
    logic [PH_W-1:0]    r_phase;
    logic               w_start_done;
    logic               w_res_done;
    logic [2:0]         r_pre;
    logic [2:0]         w_mask;
    logic               w_step;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] r_target;
    logic [3:0]         r_lives;
    logic [LEDS-1:0]    r_led;
    logic               r_blink;
    logic               w_hit;
    logic               w_led_full;

    assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_chg        = (w_next != r_state);
    assign w_start_done = tick_i && (r_phase == PH_W'(START_TICKS - 1));
    assign w_res_done   = tick_i && (r_phase == PH_W'(RESULT_TICKS - 1));
    // Prescaler step fires when the low (3-level) bits are all ones, so level is honoured live.
    assign w_mask       = 3'b111 >> level_i;
    assign w_step       = tick_i && ((r_pre & w_mask) == w_mask);
    assign w_hit        = (r_count == r_target);
    assign w_led_full   = &r_led;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_WAIT;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT:    if (go_i) w_next = S_START;
            S_START:   if (w_start_done) w_next = S_DEC;
            S_DEC:     if (stop_i) w_next = w_hit ? S_CORRECT : S_WRONG;
            S_WRONG:   if (w_res_done) w_next = (r_lives == 4'd0) ? S_LOST : S_START;
            S_CORRECT: if (w_res_done) w_next = w_led_full ? S_WON : S_START;
            S_WON:     if (go_i) w_next = S_WAIT;
            S_LOST:    if (go_i) w_next = S_WAIT;
            default:   w_next = S_WAIT;
        endcase
    end

    // Output decode
    always_comb begin
        leds_o      = r_led;
        target_en_o = 1'b0;
        count_en_o  = 1'b0;
        case (r_state)
            S_START: target_en_o = 1'b1;
            S_DEC, S_CORRECT: begin
                target_en_o = 1'b1;
                count_en_o  = 1'b1;
            end
            S_WRONG: begin
                target_en_o = 1'b1;
                count_en_o  = 1'b1;
                leds_o      = r_led ^ {LEDS{r_blink}};
            end
            S_WON: leds_o = {LEDS{r_blink}};
            S_LOST: begin
                leds_o      = '0;
                target_en_o = 1'b1;
                count_en_o  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lfsr  <= SEED;
            r_phase <= '0;
            r_blink <= 1'b0;
            r_pre   <= '0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
            if (w_chg)       r_phase <= '0;
            else if (tick_i) r_phase <= r_phase + 1'b1;
            if (w_chg)       r_blink <= 1'b0;
            else if (tick_i) r_blink <= ~r_blink;
            if (r_state != S_DEC) r_pre <= '0;
            else if (tick_i)      r_pre <= r_pre + 1'b1;
        end
    end

    // A stop taken on a step cycle wins: the count stays at the compared value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count  <= '1;
            r_target <= '0;
        end else begin
            if (w_next == S_START)
                r_count <= '1;
            else if (r_state == S_DEC && w_next == S_DEC && w_step)
                r_count <= r_count - 1'b1;
            if (w_next == S_START && r_state != S_START)
                r_target <= r_lfsr[COUNT_W-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lives <= 4'(LIVES);
        end else if (r_state == S_WAIT && go_i) begin
            r_lives <= 4'(LIVES);
        end else if (w_next == S_WRONG && r_state != S_WRONG && r_lives != 4'd0) begin
            r_lives <= r_lives - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_led <= '0;
        end else begin
            case (r_state)
                S_WAIT:  if (!go_i && load_i) r_led <= switches_i;
                S_DEC:   if (w_next == S_CORRECT) r_led <= {r_led[LEDS-2:0], 1'b1};
                S_LOST:  if (go_i) r_led <= '0;
                default: ;
            endcase
        end
    end

    assign target_o = r_target;
    assign count_o  = r_count;
    assign lives_o  = r_lives;
    assign state_o  = r_state;

endmodule

// File: tb/tb_stop_it_ng.sv
// Scoreboard bench for stop_it_ng: expectations queued at stimulus time, popped on DUT response.
module tb_stop_it_ng;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        tick_i = 1'b0;
    logic        go_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        load_i = 1'b0;
    logic [1:0]  level_i = 2'd3;
    logic [15:0] switches_i = '0;
    logic [15:0] leds_o;
    logic [7:0]  target_o;
    logic        target_en_o;
    logic [7:0]  count_o;
    logic        count_en_o;
    logic [3:0]  lives_o;
    logic [2:0]  state_o;

    always #5 clk_i = ~clk_i;

    stop_it_ng dut (
        .clk_i(clk_i), .rst_i(rst_i), .tick_i(tick_i), .go_i(go_i), .stop_i(stop_i),
        .load_i(load_i), .level_i(level_i), .switches_i(switches_i), .leds_o(leds_o),
        .target_o(target_o), .target_en_o(target_en_o), .count_o(count_o),
        .count_en_o(count_en_o), .lives_o(lives_o), .state_o(state_o)
    );

    // Reference LFSR (taps 16,14,13,11) used to predict captured targets
    logic [15:0] m_lfsr;
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) m_lfsr <= 16'h0001;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    int          n_chk = 0;
    int          n_err = 0;
    string       sb_tag[$];
    logic [31:0] sb_val[$];
    logic [7:0]  m_tgt;
    logic [7:0]  m_cnt;
    logic [15:0] m_led;
    int          m_lives;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        sb_tag.push_back(tag);
        sb_val.push_back(v);
    endtask

    task automatic pop_chk(input logic [31:0] act);
        string       t;
        logic [31:0] v;
        if (sb_val.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_empty: got %0h expected a queued entry", act);
        end else begin
            t = sb_tag.pop_front();
            v = sb_val.pop_front();
            chk(t, act, v);
        end
    endtask

    task automatic cyc(input logic t);
        tick_i = t;
        @(posedge clk_i);
        @(negedge clk_i);
        tick_i = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b1);
    endtask

    task automatic do_reset;
        rst_i = 1'b1;
        cyc(1'b0);
        rst_i = 1'b0;
        m_led = '0;
    endtask

    task automatic go_start;
        logic [7:0] snap;
        snap = m_lfsr[7:0];
        sb_push("go_state", 32'd1);
        sb_push("go_target", {24'd0, snap});
        sb_push("go_lives", 32'd3);
        sb_push("go_count", 32'hFF);
        go_i = 1'b1;
        cyc(1'b0);
        go_i = 1'b0;
        pop_chk(state_o);
        pop_chk(target_o);
        pop_chk(lives_o);
        pop_chk(count_o);
        chk("start_ten", target_en_o, 1);
        chk("start_cen", count_en_o, 0);
        m_tgt   = snap;
        m_lives = 3;
    endtask

    task automatic start_to_dec;
        ticks(7);
        chk("start_hold", state_o, 1);
        sb_push("dec_state", 32'd2);
        sb_push("dec_count", 32'hFF);
        cyc(1'b1);
        pop_chk(state_o);
        pop_chk(count_o);
        chk("dec_cen", count_en_o, 1);
    endtask

    task automatic wrong_round;
        logic [7:0] snap;
        start_to_dec();
        if (m_tgt == 8'hFF) cyc(1'b1);
        m_lives = (m_lives == 0) ? 0 : m_lives - 1;
        sb_push("wrong_state", 32'd3);
        sb_push("wrong_lives", m_lives);
        stop_i = 1'b1;
        cyc(1'b0);
        stop_i = 1'b0;
        pop_chk(state_o);
        pop_chk(lives_o);
        chk("wrong_leds0", leds_o, m_led);
        cyc(1'b1);
        chk("wrong_leds1", leds_o, m_led ^ 16'hFFFF);
        ticks(14);
        chk("wrong_hold", state_o, 3);
        snap = m_lfsr[7:0];
        cyc(1'b1);
        if (m_lives == 0) begin
            chk("lost_state", state_o, 6);
        end else begin
            chk("restart_state", state_o, 1);
            chk("new_target", target_o, snap);
            m_tgt = snap;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_led = '0;
        repeat (2) @(negedge clk_i);
        chk("rst_state", state_o, 0);
        chk("rst_leds", leds_o, 0);
        chk("rst_target", target_o, 0);
        chk("rst_count", count_o, 8'hFF);
        chk("rst_lives", lives_o, 3);
        chk("rst_ten", target_en_o, 0);
        chk("rst_cen", count_en_o, 0);
        rst_i = 1'b0;

        // Load 7FFF, stop on target: CORRECT fills the register, then WON
        switches_i = 16'h7FFF;
        load_i = 1'b1;
        cyc(1'b0);
        load_i = 1'b0;
        chk("load_leds", leds_o, 16'h7FFF);
        go_start();
        start_to_dec();
        m_cnt = 8'hFF;
        while (m_cnt != m_tgt) begin
            cyc(1'b1);
            m_cnt = m_cnt - 8'd1;
        end
        chk("count_at_tgt", count_o, m_tgt);
        sb_push("correct_state", 32'd4);
        sb_push("correct_leds", 32'hFFFF);
        stop_i = 1'b1;
        cyc(1'b0);
        stop_i = 1'b0;
        pop_chk(state_o);
        pop_chk(leds_o);
        ticks(15);
        chk("correct_hold", state_o, 4);
        cyc(1'b1);
        chk("won_state", state_o, 5);
        chk("won_blink0", leds_o, 16'h0000);
        cyc(1'b1);
        chk("won_blink1", leds_o, 16'hFFFF);
        go_i = 1'b1;
        cyc(1'b0);
        go_i = 1'b0;
        chk("won_exit", state_o, 0);
        chk("won_keep_leds", leds_o, 16'hFFFF);

        // Three wrong stops: lives 3->2->1->0, LOST, go clears the register
        do_reset();
        switches_i = 16'h00F0;
        load_i = 1'b1;
        cyc(1'b0);
        load_i = 1'b0;
        m_led = 16'h00F0;
        go_start();
        repeat (3) wrong_round();
        chk("lost_leds", leds_o, 0);
        chk("lost_ten", target_en_o, 1);
        chk("lost_cen", count_en_o, 1);
        chk("lost_lives", lives_o, 0);
        go_i = 1'b1;
        cyc(1'b0);
        go_i = 1'b0;
        chk("lost_exit", state_o, 0);
        chk("lost_cleared", leds_o, 0);

        // Level 0 steps every 8 ticks, level 3 every tick, count wraps 0 -> FF
        do_reset();
        level_i = 2'd0;
        go_start();
        start_to_dec();
        ticks(7);
        chk("lvl0_hold", count_o, 8'hFF);
        cyc(1'b1);
        chk("lvl0_step", count_o, 8'hFE);
        level_i = 2'd3;
        cyc(1'b1);
        chk("lvl3_step", count_o, 8'hFD);
        m_cnt = 8'hFD;
        while (m_cnt != 8'h00) begin
            cyc(1'b1);
            m_cnt = m_cnt - 8'd1;
        end
        chk("count_zero", count_o, 8'h00);
        cyc(1'b1);
        chk("count_wrap", count_o, 8'hFF);

        // Stop on a step cycle compares the pre-step count
        do_reset();
        go_start();
        start_to_dec();
        m_cnt = 8'hFF;
        while (m_cnt != m_tgt) begin
            cyc(1'b1);
            m_cnt = m_cnt - 8'd1;
        end
        sb_push("coinc_state", 32'd4);
        sb_push("coinc_count", {24'd0, m_tgt});
        sb_push("coinc_leds", 32'h0001);
        stop_i = 1'b1;
        cyc(1'b1);
        stop_i = 1'b0;
        pop_chk(state_o);
        pop_chk(count_o);
        pop_chk(leds_o);
        ticks(15);
        m_cnt = m_lfsr[7:0];
        cyc(1'b1);
        chk("coinc_restart", state_o, 1);
        chk("coinc_target", target_o, m_cnt);

        // Async reset mid-DECREMENTING, then go+load together
        do_reset();
        switches_i = 16'h5A5A;
        load_i = 1'b1;
        cyc(1'b0);
        load_i = 1'b0;
        m_led = 16'h5A5A;
        go_start();
        wrong_round();
        start_to_dec();
        ticks(2);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_state", state_o, 0);
        chk("arst_leds", leds_o, 0);
        chk("arst_lives", lives_o, 3);
        chk("arst_count", count_o, 8'hFF);
        @(negedge clk_i);
        rst_i = 1'b0;
        switches_i = 16'h1234;
        load_i = 1'b1;
        cyc(1'b0);
        load_i = 1'b0;
        chk("reload_leds", leds_o, 16'h1234);
        switches_i = 16'hABCD;
        sb_push("goload_state", 32'd1);
        sb_push("goload_leds", 32'h1234);
        sb_push("goload_target", {24'd0, m_lfsr[7:0]});
        load_i = 1'b1;
        go_i = 1'b1;
        cyc(1'b0);
        go_i = 1'b0;
        load_i = 1'b0;
        pop_chk(state_o);
        pop_chk(leds_o);
        pop_chk(target_o);

        chk("sb_drain", sb_val.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
